// File: rtl/cpu_datapath_if.sv
// Control word and observation bundle between the CPU control unit and the datapath.
// Latency: none (wires only).
// Backpressure: none; the control word is applied every cycle.
interface cpu_datapath_if #(
  parameter int WIDTH = 8
);
  // control word and external data (control unit -> datapath)
  logic [WIDTH-1:0] Din;
  logic             Entern;
  logic             Gout;
  logic             Rout0, Rout1, Rout2, Rout3;
  logic             Rin0, Rin1, Rin2, Rin3;
  logic             Ain;
  logic             Gin;
  logic             AddSub;
  logic             clr_conflict;

  // observation (datapath -> control unit / debug)
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] r0, r1, r2, r3;
  logic [WIDTH-1:0] a_q, g_q;
  logic             cout;
  logic             bus_conflict;

  // control unit side
  modport master (
    output Din, Entern, Gout, Rout0, Rout1, Rout2, Rout3,
           Rin0, Rin1, Rin2, Rin3, Ain, Gin, AddSub, clr_conflict,
    input  bus, r0, r1, r2, r3, a_q, g_q, cout, bus_conflict
  );

  // datapath side
  modport slave (
    input  Din, Entern, Gout, Rout0, Rout1, Rout2, Rout3,
           Rin0, Rin1, Rin2, Rin3, Ain, Gin, AddSub, clr_conflict,
    output bus, r0, r1, r2, r3, a_q, g_q, cout, bus_conflict
  );
endinterface

// File: rtl/cpu_datapath.sv
// Executes one register-transfer control word per cycle: bus mux, R0-R3, A, G, add/sub ALU.
// Latency: bus is combinational; register/flag updates visible one cycle after the enabling edge.
// Backpressure: none; every control word, legal or not, is executed deterministically.
module cpu_datapath #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  cpu_datapath_if.slave dp
);

  // storage
  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [WIDTH-1:0] g_reg_q, g_reg_d;
  logic             cout_q, cout_d;
  logic             conflict_q, conflict_d;

  // combinational datapath nets
  logic [3:0]       rout;
  logic [3:0]       rin;
  logic [WIDTH-1:0] bus_w;
  logic [2:0]       src_cnt;
  logic             multi_src;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;

  assign rout = {dp.Rout3, dp.Rout2, dp.Rout1, dp.Rout0};
  assign rin  = {dp.Rin3,  dp.Rin2,  dp.Rin1,  dp.Rin0};

  // Bus source select, fixed priority Din > G > R0 > R1 > R2 > R3, idle bus reads zero.
  always_comb begin
    bus_w = '0;
    if (dp.Entern)     bus_w = dp.Din;
    else if (dp.Gout)  bus_w = g_reg_q;
    else if (rout[0])  bus_w = r_q[0];
    else if (rout[1])  bus_w = r_q[1];
    else if (rout[2])  bus_w = r_q[2];
    else if (rout[3])  bus_w = r_q[3];
  end

  // Count enabled bus drivers; more than one is a control-word error worth flagging.
  always_comb begin
    src_cnt = 3'(dp.Entern) + 3'(dp.Gout) + 3'(rout[0]) + 3'(rout[1])
            + 3'(rout[2]) + 3'(rout[3]);
    multi_src = (src_cnt > 3'd1);
  end

  // ALU on the pre-edge A and current bus. The extra top bit of the sum is the carry;
  // for the difference it goes high exactly when A < bus, which is the unsigned borrow.
  always_comb begin
    add_w = {1'b0, a_reg_q} + {1'b0, bus_w};
    sub_w = {1'b0, a_reg_q} - {1'b0, bus_w};
  end

  // Next-state: every storage element defaults to hold, enables pick the bus or ALU value.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r_d[i] = rin[i] ? bus_w : r_q[i];
    end
    a_reg_d = dp.Ain ? bus_w : a_reg_q;

    g_reg_d = g_reg_q;
    cout_d  = cout_q;
    if (dp.Gin) begin
      if (dp.AddSub) begin
        g_reg_d = add_w[WIDTH-1:0];
        cout_d  = add_w[WIDTH];
      end else begin
        g_reg_d = sub_w[WIDTH-1:0];
        cout_d  = sub_w[WIDTH];
      end
    end

    // a fresh conflict outranks a clear request in the same cycle
    conflict_d = conflict_q;
    if (multi_src)            conflict_d = 1'b1;
    else if (dp.clr_conflict) conflict_d = 1'b0;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= '0;
      end
      a_reg_q    <= '0;
      g_reg_q    <= '0;
      cout_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= r_d[i];
      end
      a_reg_q    <= a_reg_d;
      g_reg_q    <= g_reg_d;
      cout_q     <= cout_d;
      conflict_q <= conflict_d;
    end
  end

  assign dp.bus          = bus_w;
  assign dp.r0           = r_q[0];
  assign dp.r1           = r_q[1];
  assign dp.r2           = r_q[2];
  assign dp.r3           = r_q[3];
  assign dp.a_q          = a_reg_q;
  assign dp.g_q          = g_reg_q;
  assign dp.cout         = cout_q;
  assign dp.bus_conflict = conflict_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with hand-computed expectations.
// Latency: checks bus before the edge and registers 1 ns after it.
// Backpressure: none; the bench drives one control word per cycle.
module tb_cpu_datapath;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  cpu_datapath_if #(.WIDTH(8)) dp_if ();

  cpu_datapath #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  always #5 clk = ~clk;

  // compare one observed value against its expectation
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dp_if.Din = '0;
    dp_if.Entern = 0; dp_if.Gout = 0;
    dp_if.Rout0 = 0; dp_if.Rout1 = 0; dp_if.Rout2 = 0; dp_if.Rout3 = 0;
    dp_if.Rin0 = 0;  dp_if.Rin1 = 0;  dp_if.Rin2 = 0;  dp_if.Rin3 = 0;
    dp_if.Ain = 0; dp_if.Gin = 0; dp_if.AddSub = 0; dp_if.clr_conflict = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Din -> R[idx]
  task automatic load_r(input int idx, input logic [7:0] val);
    idle();
    dp_if.Din = val; dp_if.Entern = 1;
    case (idx)
      0: dp_if.Rin0 = 1;
      1: dp_if.Rin1 = 1;
      2: dp_if.Rin2 = 1;
      default: dp_if.Rin3 = 1;
    endcase
    tick();
    idle();
  endtask

  // Din -> A
  task automatic load_a(input logic [7:0] val);
    idle();
    dp_if.Din = val; dp_if.Entern = 1; dp_if.Ain = 1;
    tick();
    idle();
  endtask

  // A op Din -> G
  task automatic alu_din(input logic [7:0] val, input logic add);
    idle();
    dp_if.Din = val; dp_if.Entern = 1; dp_if.Gin = 1; dp_if.AddSub = add;
    tick();
    idle();
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_r0"}, 32'(dp_if.r0), 32'h0);
    check_val({pfx, "_r1"}, 32'(dp_if.r1), 32'h0);
    check_val({pfx, "_r2"}, 32'(dp_if.r2), 32'h0);
    check_val({pfx, "_r3"}, 32'(dp_if.r3), 32'h0);
    check_val({pfx, "_a"},  32'(dp_if.a_q), 32'h0);
    check_val({pfx, "_g"},  32'(dp_if.g_q), 32'h0);
    check_val({pfx, "_cout"}, 32'(dp_if.cout), 32'h0);
    check_val({pfx, "_conf"}, 32'(dp_if.bus_conflict), 32'h0);
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    #2;
    check_all_zero("por");
    check_val("por_bus_idle", 32'(dp_if.bus), 32'h0);
    #9 reset = 1'b0;          // t=12, between edges
    tick();

    // fill with random contents and set the conflict flag
    for (int i = 0; i < 4; i++) load_r(i, 8'($urandom_range(1, 255)));
    load_a(8'($urandom_range(1, 255)));
    alu_din(8'($urandom_range(1, 255)), 1'b1);
    dp_if.Entern = 1; dp_if.Gout = 1; dp_if.Din = 8'hA5;
    tick();
    idle();
    check_val("pre_rst_conf", 32'(dp_if.bus_conflict), 32'h1);

    // asynchronous reset between edges zeroes everything at once
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    #2 reset = 1'b0;
    tick();

    // load: Din=0x35 into R2
    dp_if.Din = 8'h35; dp_if.Entern = 1; dp_if.Rin2 = 1;
    #1;
    check_val("load_bus", 32'(dp_if.bus), 32'h35);
    tick();
    idle();
    check_val("load_r2", 32'(dp_if.r2), 32'h35);
    check_val("load_r0", 32'(dp_if.r0), 32'h0);
    check_val("load_r3", 32'(dp_if.r3), 32'h0);
    check_val("load_a",  32'(dp_if.a_q), 32'h0);

    // Rin with Rout of the same register holds its value
    dp_if.Rout2 = 1; dp_if.Rin2 = 1;
    tick();
    idle();
    check_val("self_reload_r2", 32'(dp_if.r2), 32'h35);

    // add sequence R0=5, R1=3
    load_r(0, 8'h05);
    load_r(1, 8'h03);
    dp_if.Rout0 = 1; dp_if.Ain = 1;
    tick(); idle();
    check_val("add_a", 32'(dp_if.a_q), 32'h05);
    dp_if.Rout1 = 1; dp_if.Gin = 1; dp_if.AddSub = 1;
    tick(); idle();
    check_val("add_g", 32'(dp_if.g_q), 32'h08);
    check_val("add_cout", 32'(dp_if.cout), 32'h0);
    dp_if.Gout = 1; dp_if.Rin3 = 1;
    #1;
    check_val("gout_bus", 32'(dp_if.bus), 32'h08);
    tick(); idle();
    check_val("gout_r3", 32'(dp_if.r3), 32'h08);

    // subtract with borrow: 2 - 5
    load_a(8'h02);
    alu_din(8'h05, 1'b0);
    check_val("sub_wrap_g", 32'(dp_if.g_q), 32'hFD);
    check_val("sub_wrap_cout", 32'(dp_if.cout), 32'h1);

    // Gin=0 holds G and cout whatever AddSub says
    dp_if.Din = 8'h40; dp_if.Entern = 1; dp_if.AddSub = 1;
    tick(); idle();
    check_val("hold_g", 32'(dp_if.g_q), 32'hFD);
    check_val("hold_cout", 32'(dp_if.cout), 32'h1);

    // add with carry: FF + 1
    load_a(8'hFF);
    alu_din(8'h01, 1'b1);
    check_val("add_wrap_g", 32'(dp_if.g_q), 32'h00);
    check_val("add_wrap_cout", 32'(dp_if.cout), 32'h1);

    // subtract without borrow: 0x30 - 0x30
    load_a(8'h30);
    alu_din(8'h30, 1'b0);
    check_val("sub_eq_g", 32'(dp_if.g_q), 32'h00);
    check_val("sub_eq_cout", 32'(dp_if.cout), 32'h0);

    // Ain and Gin together: G uses the old A
    load_a(8'h10);
    dp_if.Din = 8'h01; dp_if.Entern = 1; dp_if.Ain = 1; dp_if.Gin = 1; dp_if.AddSub = 1;
    tick(); idle();
    check_val("ain_gin_a", 32'(dp_if.a_q), 32'h01);
    check_val("ain_gin_g", 32'(dp_if.g_q), 32'h11);

    // Gin with Gout: G <= A + old G = 0x01 + 0x11
    dp_if.Gout = 1; dp_if.Gin = 1; dp_if.AddSub = 1;
    tick(); idle();
    check_val("gin_gout_g", 32'(dp_if.g_q), 32'h12);

    // conflict: R0=0x11, R1=0x22 both driven
    load_r(0, 8'h11);
    load_r(1, 8'h22);
    check_val("conf_before", 32'(dp_if.bus_conflict), 32'h0);
    dp_if.Rout0 = 1; dp_if.Rout1 = 1;
    #1;
    check_val("conf_bus_prio", 32'(dp_if.bus), 32'h11);
    tick(); idle();
    check_val("conf_set", 32'(dp_if.bus_conflict), 32'h1);
    repeat (5) tick();
    check_val("conf_sticky", 32'(dp_if.bus_conflict), 32'h1);
    dp_if.clr_conflict = 1;
    tick(); idle();
    check_val("conf_clr", 32'(dp_if.bus_conflict), 32'h0);

    // lower-priority pair: R2 wins over R3
    dp_if.Rout2 = 1; dp_if.Rout3 = 1;
    #1;
    check_val("prio_r2_r3", 32'(dp_if.bus), 32'h35);
    idle();

    // conflict beats a simultaneous clear; Din wins the bus over G
    dp_if.clr_conflict = 1; dp_if.Entern = 1; dp_if.Gout = 1; dp_if.Din = 8'h5A;
    #1;
    check_val("prio_din_g", 32'(dp_if.bus), 32'h5A);
    tick(); idle();
    check_val("conf_clr_lose", 32'(dp_if.bus_conflict), 32'h1);

    // reset mid-operation between the Ain and Gin steps
    load_a(8'h07);
    check_val("mid_a", 32'(dp_if.a_q), 32'h07);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    dp_if.Rout0 = 1; dp_if.Gin = 1; dp_if.AddSub = 1;
    tick(); idle();
    check_val("mid_rst_g", 32'(dp_if.g_q), 32'h00);
    check_val("mid_rst_cout", 32'(dp_if.cout), 32'h0);
    check_val("mid_rst_a", 32'(dp_if.a_q), 32'h00);
    check_val("mid_rst_conf", 32'(dp_if.bus_conflict), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
